run_packer_16: RTL and testbench

RUN_PACKER_16 -- requirements
Module: run_packer_16

---
 rtl/run_packer_16.sv | 168 ++++++++++++++++
 tb/tb_run_packer_16.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/run_packer_16.sv
// run_packer_16: packs an ascending tuple stream into 16-lane words for the
// merger input FIFO. A run ends with a padded word followed by an all-zero
// terminator word. Sticky flags report zero tuples and key descent in a run.
module run_packer_16 #(
  parameter int DATA_WIDTH = 128,
  parameter int KEY_WIDTH  = 80
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [DATA_WIDTH-1:0]    i_tuple,
  input  logic                     i_tuple_valid,
  input  logic                     i_last,
  output logic                     o_tuple_ready,
  output logic [16*DATA_WIDTH-1:0] o_data,
  output logic                     o_empty,
  input  logic                     i_read,
  output logic                     o_err_zero,
  output logic                     o_err_order,
  output logic [15:0]              o_runs_done
);

  localparam int LANES  = 16;
  localparam int WORD_W = LANES * DATA_WIDTH;

  typedef enum logic [0:0] {
    PACK = 1'b0,
    TERM = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [3:0]            lane_cnt_r;
  logic [WORD_W-1:0]     word_r;
  logic [WORD_W-1:0]     filled_s;
  logic [WORD_W-1:0]     enq_data_s;
  logic [WORD_W-1:0]     q_mem_r [0:1];
  logic                  q_wr_r;
  logic                  q_rd_r;
  logic [1:0]            q_cnt_r;
  logic [KEY_WIDTH-1:0]  prev_key_r;
  logic                  run_start_r;
  logic                  err_zero_r;
  logic                  err_order_r;
  logic [15:0]           runs_r;

  logic room_s;
  logic ready_s;
  logic xfer_s;
  logic word_done_s;
  logic term_enq_s;
  logic enq_s;
  logic deq_s;

  // Handshake and queue control; ready looks only at the count before any read.
  always_comb begin
    room_s      = (q_cnt_r < 2'd2);
    ready_s     = (!i_rst) && (state_r == PACK) && room_s;
    xfer_s      = i_tuple_valid && ready_s;
    word_done_s = xfer_s && ((lane_cnt_r == 4'd15) || i_last);
    term_enq_s  = (state_r == TERM) && room_s;
    enq_s       = word_done_s || term_enq_s;
    deq_s       = i_read && (q_cnt_r != 2'd0);
    if (term_enq_s) begin
      enq_data_s = '0;
    end else begin
      enq_data_s = filled_s;
    end
  end

  // Word being built: earlier lanes kept, current lane takes the tuple, higher lanes padded with ones.
  always_comb begin
    filled_s = '0;
    for (int k = 0; k < LANES; k++) begin
      if (4'(k) < lane_cnt_r) begin
        filled_s[k*DATA_WIDTH +: DATA_WIDTH] = word_r[k*DATA_WIDTH +: DATA_WIDTH];
      end else if (4'(k) == lane_cnt_r) begin
        filled_s[k*DATA_WIDTH +: DATA_WIDTH] = i_tuple;
      end else begin
        filled_s[k*DATA_WIDTH +: DATA_WIDTH] = '1;
      end
    end
  end

  // Next-state logic: a last tuple sends us to TERM, which waits for queue room.
  always_comb begin
    state_s = state_r;
    case (state_r)
      PACK: begin
        if (xfer_s && i_last) state_s = TERM;
        else                  state_s = PACK;
      end
      TERM: begin
        if (room_s) state_s = PACK;
        else        state_s = TERM;
      end
      default: state_s = PACK;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_r <= PACK;
    else       state_r <= state_s;
  end

  // Lane counter and partial word; a completed word restarts at lane 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lane_cnt_r <= 4'd0;
      word_r     <= '0;
    end else if (xfer_s) begin
      word_r <= filled_s;
      if (word_done_s) lane_cnt_r <= 4'd0;
      else             lane_cnt_r <= lane_cnt_r + 4'd1;
    end
  end

  // Two-entry output queue with independent enqueue and dequeue pointers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      q_mem_r[0] <= '0;
      q_mem_r[1] <= '0;
      q_wr_r     <= 1'b0;
      q_rd_r     <= 1'b0;
      q_cnt_r    <= 2'd0;
    end else begin
      if (enq_s) begin
        q_mem_r[q_wr_r] <= enq_data_s;
        q_wr_r          <= ~q_wr_r;
      end
      if (deq_s) q_rd_r <= ~q_rd_r;
      case ({enq_s, deq_s})
        2'b10:   q_cnt_r <= q_cnt_r + 2'd1;
        2'b01:   q_cnt_r <= q_cnt_r - 2'd1;
        default: q_cnt_r <= q_cnt_r;
      endcase
    end
  end

  // Sticky error flags; key ordering restarts after each last tuple.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_zero_r  <= 1'b0;
      err_order_r <= 1'b0;
      prev_key_r  <= '0;
      run_start_r <= 1'b1;
    end else if (xfer_s) begin
      if (i_tuple == '0) err_zero_r <= 1'b1;
      if (!run_start_r && (i_tuple[KEY_WIDTH-1:0] < prev_key_r)) err_order_r <= 1'b1;
      prev_key_r  <= i_tuple[KEY_WIDTH-1:0];
      run_start_r <= i_last;
    end
  end

  // Terminator counter, bumped whenever the zero word is enqueued.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)           runs_r <= 16'd0;
    else if (term_enq_s) runs_r <= runs_r + 16'd1;
  end

  assign o_tuple_ready = ready_s;
  assign o_empty       = (q_cnt_r == 2'd0);
  assign o_data        = (q_cnt_r == 2'd0) ? '0 : q_mem_r[q_rd_r];
  assign o_err_zero    = err_zero_r;
  assign o_err_order   = err_order_r;
  assign o_runs_done   = runs_r;

endmodule

// File: tb/tb_run_packer_16.sv
// tb_run_packer_16: scoreboard bench. Accepted tuples feed a packing model that
// queues expected words; each dequeued DUT word is compared lane by lane.
module tb_run_packer_16;

  localparam int DW = 128;
  typedef logic [16*DW-1:0] word_t;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [DW-1:0] i_tuple;
  logic          i_tuple_valid;
  logic          i_last;
  logic          o_tuple_ready;
  word_t         o_data;
  logic          o_empty;
  logic          i_read;
  logic          o_err_zero;
  logic          o_err_order;
  logic [15:0]   o_runs_done;

  int      n_vec = 0;
  int      n_bad = 0;
  word_t   exp_q[$];
  logic [DW-1:0] m_lanes [16];
  int      m_cnt = 0;
  int      runs_exp = 0;

  run_packer_16 dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_tuple(i_tuple), .i_tuple_valid(i_tuple_valid),
    .i_last(i_last), .o_tuple_ready(o_tuple_ready), .o_data(o_data), .o_empty(o_empty),
    .i_read(i_read), .o_err_zero(o_err_zero), .o_err_order(o_err_order),
    .o_runs_done(o_runs_done)
  );

  // Free-running clock.
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int key);
    return {16'hBEEF, 32'(key), 80'(key)};
  endfunction

  // Reference packing: lanes fill from 0, pad with ones, zero word after a last.
  task automatic model_accept(input logic [DW-1:0] t, input logic last);
    word_t w;
    m_lanes[m_cnt] = t;
    if (m_cnt == 15 || last) begin
      w = '0;
      for (int k = 0; k < 16; k++) begin
        if (k <= m_cnt) w[k*DW +: DW] = m_lanes[k];
        else            w[k*DW +: DW] = '1;
      end
      exp_q.push_back(w);
      m_cnt = 0;
      if (last) begin
        exp_q.push_back('0);
        runs_exp++;
      end
    end else begin
      m_cnt++;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt = 0;
    runs_exp = 0;
  endtask

  // One clock: sample at the falling edge, score dequeues, then advance.
  task automatic cycle(output bit acc);
    word_t w;
    @(negedge i_clk);
    acc = i_tuple_valid && o_tuple_ready;
    if (i_read && !o_empty) begin
      if (exp_q.size() == 0) begin
        check("extra_word", 128'(1), 128'(0));
      end else begin
        w = exp_q.pop_front();
        for (int k = 0; k < 16; k++) check("lane", o_data[k*DW +: DW], w[k*DW +: DW]);
      end
    end
    if (acc) model_accept(i_tuple, i_last);
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] t, input logic last);
    bit acc;
    int n;
    n = 0;
    i_tuple = t; i_last = last; i_tuple_valid = 1'b1;
    do begin
      cycle(acc);
      n++;
    end while (!acc && n < 200);
    if (!acc) check("send_timeout", 128'(0), 128'(1));
    i_tuple_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    i_read = 1'b1;
    while ((exp_q.size() != 0 || !o_empty) && n < 100) begin
      cycle(acc);
      n++;
    end
    check("drain_empty", 128'(o_empty), 128'(1));
    check("sb_empty", 128'(exp_q.size()), 128'(0));
    check("runs_done", 128'(o_runs_done), 128'(runs_exp));
    i_read = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    bit acc;
    i_rst = 1'b1; i_tuple = '0; i_tuple_valid = 1'b0; i_last = 1'b0; i_read = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_empty", 128'(o_empty), 128'(1));
    check("rst_ready", 128'(o_tuple_ready), 128'(0));
    check("rst_data", 128'(o_data == '0), 128'(1));
    check("rst_runs", 128'(o_runs_done), 128'(0));
    i_rst = 1'b0;
    #1;
    check("ready_after_rst", 128'(o_tuple_ready), 128'(1));

    // Full run of 16 keys with reads enabled.
    i_read = 1'b1;
    for (int i = 1; i <= 16; i++) send(mk(i), (i == 16));
    drain();

    // Short run of three keys, padded with ones.
    for (int i = 5; i <= 7; i++) send(mk(i), (i == 7));
    drain();

    // Backpressure: two words fill the queue, tuple 33 is held.
    i_read = 1'b0;
    for (int i = 1; i <= 32; i++) send(mk(i), 1'b0);
    i_tuple = mk(33); i_last = 1'b0; i_tuple_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      check("held_ready", 128'(o_tuple_ready), 128'(0));
      cycle(acc);
      check("held_acc", 128'(acc), 128'(0));
    end
    check("full_not_empty", 128'(o_empty), 128'(0));
    i_read = 1'b1;
    send(mk(33), 1'b0);
    for (int i = 34; i <= 48; i++) send(mk(i), (i == 48));
    drain();
    check("order_clean", 128'(o_err_order), 128'(0));
    check("zero_clean", 128'(o_err_zero), 128'(0));

    // Descending keys within a run set the order flag.
    send(mk(9), 1'b0);
    send(mk(4), 1'b1);
    drain();
    check("order_set", 128'(o_err_order), 128'(1));
    send(mk(1), 1'b0);
    send(mk(2), 1'b1);
    drain();
    check("order_sticky", 128'(o_err_order), 128'(1));
    check("zero_still_clean", 128'(o_err_zero), 128'(0));

    // An all-zero tuple raises the zero flag and is still packed.
    send('0, 1'b1);
    drain();
    check("zero_set", 128'(o_err_zero), 128'(1));

    // Reset with one word queued and seven tuples in a partial word.
    i_read = 1'b0;
    for (int i = 10; i <= 32; i++) send(mk(i), 1'b0);
    check("pre_rst_full", 128'(o_empty), 128'(0));
    i_rst = 1'b1;
    #1;
    check("mid_rst_empty", 128'(o_empty), 128'(1));
    check("mid_rst_data", 128'(o_data == '0), 128'(1));
    check("mid_rst_ready", 128'(o_tuple_ready), 128'(0));
    check("mid_rst_zero", 128'(o_err_zero), 128'(0));
    check("mid_rst_order", 128'(o_err_order), 128'(0));
    check("mid_rst_runs", 128'(o_runs_done), 128'(0));
    model_reset();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    #1;
    check("ready_after_rst2", 128'(o_tuple_ready), 128'(1));
    send(mk(3), 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
